// File: rtl/fb_loader.sv
// fb_loader: packs pairs of incoming pixel bytes into 16-bit frame-buffer word writes.
// Ports:
//   clk, reset_n      - single clock, synchronous active-low reset
//   byte_in/valid     - pixel byte stream (8 pixels per byte), accepted when byte_ready is high
//   byte_ready        - loader can accept a byte this cycle
//   frame_start       - restart at word 0, dropping any half-packed word
//   clear_req         - zero-fill the whole frame (only with FB_LOADER_CLEAR_EN defined)
//   write_address/data, load - one-cycle frame-buffer write strobe with address and data
//   frame_done        - pulses with the load of the last word of a frame
// Build option: define FB_LOADER_CLEAR_EN to add clear_req and the CLEAR state.
module fb_loader #(
    parameter int WORDS_PER_FRAME = 24000,
    parameter bit HIGH_FIRST      = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        frame_start,
`ifdef FB_LOADER_CLEAR_EN
    input  logic        clear_req,
`endif
    output logic [15:0] write_address,
    output logic [15:0] write_data,
    output logic        load,
    output logic        frame_done
);
    localparam logic [15:0] LAST = 16'(WORDS_PER_FRAME - 1);

`ifdef FB_LOADER_CLEAR_EN
    typedef enum logic [1:0] {ACCEPT_HI, ACCEPT_LO, CLEAR} state_t;
`else
    typedef enum logic {ACCEPT_HI, ACCEPT_LO} state_t;
`endif

    state_t      state, state_n, eff_state;
    logic [15:0] ptr, ptr_n, eff_ptr, addr_n, data_n;
    logic [7:0]  held, held_n;
    logic        load_n, done_n, accept;

`ifdef FB_LOADER_CLEAR_EN
    assign byte_ready = reset_n && state != CLEAR;
`else
    assign byte_ready = reset_n;
`endif
    assign accept = byte_valid && byte_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ACCEPT_HI;
            ptr           <= '0;
            held          <= '0;
            write_address <= '0;
            write_data    <= '0;
            load          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_n;
            ptr           <= ptr_n;
            held          <= held_n;
            write_address <= addr_n;
            write_data    <= data_n;
            load          <= load_n;
            frame_done    <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        held_n    = held;
        addr_n    = write_address;
        data_n    = write_data;
        load_n    = 1'b0;
        done_n    = 1'b0;
        // frame_start takes effect before a byte accepted in the same cycle
        eff_state = frame_start ? ACCEPT_HI : state;
        eff_ptr   = frame_start ? '0 : ptr;
`ifdef FB_LOADER_CLEAR_EN
        if (state == CLEAR) begin
            // Leave only after the last zero word is on the bus, keeping byte_ready low through it
            if (frame_done) begin
                state_n = ACCEPT_HI;
            end else begin
                load_n = 1'b1;
                addr_n = ptr;
                data_n = '0;
                done_n = ptr == LAST;
                ptr_n  = ptr == LAST ? '0 : ptr + 16'd1;
            end
        end else if (clear_req) begin
            state_n = CLEAR;
            ptr_n   = '0;
            held_n  = '0;
        end else
`endif
        if (!accept) begin
            state_n = eff_state;
            ptr_n   = eff_ptr;
            held_n  = frame_start ? '0 : held;
        end else if (eff_state == ACCEPT_HI) begin
            state_n = ACCEPT_LO;
            ptr_n   = eff_ptr;
            held_n  = byte_in;
        end else begin
            state_n = ACCEPT_HI;
            ptr_n   = eff_ptr == LAST ? '0 : eff_ptr + 16'd1;
            held_n  = '0;
            load_n  = 1'b1;
            addr_n  = eff_ptr;
            data_n  = HIGH_FIRST ? {held, byte_in} : {byte_in, held};
            done_n  = eff_ptr == LAST;
        end
    end
endmodule

// File: tb/tb_fb_loader.sv
// tb_fb_loader: self-checking bench for fb_loader with a cycle monitor against a byte-pair reference model.
module tb_fb_loader;
    localparam int W = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0, byte_valid = 1'b0, frame_start = 1'b0, clear_req = 1'b0;
    logic [7:0]  byte_in = '0;
    logic [15:0] addr_h, data_h, addr_l, data_l;
    logic        ready_h, load_h, done_h, ready_l, load_l, done_l;
    int          n_checks = 0, n_fail = 0;

    bit          m_have = 0, m_load = 0, m_done = 0, m_ready;
    logic [7:0]  m_first = '0;
    int          m_ptr = 0, m_clr = 0;
    logic [15:0] m_addr = '0, m_hi = '0, m_lo = '0;

    always #5 clk = ~clk;

    fb_loader #(.WORDS_PER_FRAME(W), .HIGH_FIRST(1)) dut_hi (
        .clk(clk), .reset_n(reset_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(ready_h), .frame_start(frame_start),
`ifdef FB_LOADER_CLEAR_EN
        .clear_req(clear_req),
`endif
        .write_address(addr_h), .write_data(data_h), .load(load_h), .frame_done(done_h));

    fb_loader #(.WORDS_PER_FRAME(W), .HIGH_FIRST(0)) dut_lo (
        .clk(clk), .reset_n(reset_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(ready_l), .frame_start(frame_start),
`ifdef FB_LOADER_CLEAR_EN
        .clear_req(clear_req),
`endif
        .write_address(addr_l), .write_data(data_l), .load(load_l), .frame_done(done_l));

    // Reference model: bytes pair up into words written one cycle later at a wrapping word index;
    // a clear emits W zero words and holds byte_ready low for W+1 cycles.
    always @(posedge clk) begin
        m_load = 0;
        m_done = 0;
        if (reset_n !== 1'b1) begin
            m_have = 0; m_first = '0; m_ptr = 0; m_clr = 0; m_addr = '0; m_hi = '0; m_lo = '0;
        end else if (m_clr > 0) begin
            if (m_clr > 1) begin
                m_load = 1; m_addr = 16'(m_ptr); m_hi = '0; m_lo = '0;
                m_done = m_ptr == W - 1;
                m_ptr = (m_ptr + 1) % W;
            end
            m_clr--;
        end
`ifdef FB_LOADER_CLEAR_EN
        else if (clear_req) begin
            m_clr = W + 1; m_ptr = 0; m_have = 0;
        end
`endif
        else begin
            if (frame_start) begin
                m_have = 0; m_ptr = 0;
            end
            if (byte_valid) begin
                if (!m_have) begin
                    m_have = 1; m_first = byte_in;
                end else begin
                    m_load = 1; m_addr = 16'(m_ptr);
                    m_hi = {m_first, byte_in}; m_lo = {byte_in, m_first};
                    m_done = m_ptr == W - 1;
                    m_ptr = (m_ptr + 1) % W;
                    m_have = 0;
                end
            end
        end
        #1;
        m_ready = (reset_n === 1'b1) && m_clr == 0;
        n_checks++;
        if ({ready_h, ready_l} !== {2{m_ready}}) begin
            n_fail++; $display("FAIL mon_ready t=%0t: got %b%b expected %b", $time, ready_h, ready_l, m_ready);
        end
        n_checks++;
        if ({load_h, load_l} !== {2{m_load}}) begin
            n_fail++; $display("FAIL mon_load t=%0t: got %b%b expected %b", $time, load_h, load_l, m_load);
        end
        n_checks++;
        if ({addr_h, addr_l} !== {2{m_addr}}) begin
            n_fail++; $display("FAIL mon_addr t=%0t: got %h/%h expected %h", $time, addr_h, addr_l, m_addr);
        end
        n_checks++;
        if ({data_h, data_l} !== {m_hi, m_lo}) begin
            n_fail++; $display("FAIL mon_data t=%0t: got %h/%h expected %h/%h", $time, data_h, data_l, m_hi, m_lo);
        end
        n_checks++;
        if ({done_h, done_l} !== {2{m_done}}) begin
            n_fail++; $display("FAIL mon_done t=%0t: got %b%b expected %b", $time, done_h, done_l, m_done);
        end
    end

    task automatic drive(input logic rn, input logic fs, input logic cr, input logic bv, input logic [7:0] b);
        @(negedge clk);
        reset_n = rn; frame_start = fs; clear_req = cr; byte_valid = bv; byte_in = b;
        #1;
    endtask

    task automatic test_reset;
        drive(0, 1, 0, 1, 8'hFF);
        drive(0, 0, 0, 1, 8'h5A);
        n_checks++;
        if ({ready_h, load_h, done_h, addr_h, data_h} !== 35'd0) begin
            n_fail++; $display("FAIL reset_state: got rdy=%b ld=%b dn=%b a=%h d=%h expected all zero", ready_h, load_h, done_h, addr_h, data_h);
        end
    endtask

    task automatic test_basic;
        drive(1, 0, 0, 1, 8'hDE);
        drive(1, 0, 0, 1, 8'hED);
        drive(1, 0, 0, 1, 8'h00);
        n_checks++;
        if ({load_h, addr_h, data_h, data_l} !== {1'b1, 16'h0000, 16'hDEED, 16'hEDDE}) begin
            n_fail++; $display("FAIL basic_w0: got %b %h %h %h expected 1 0000 deed edde", load_h, addr_h, data_h, data_l);
        end
        drive(1, 0, 0, 1, 8'h07);
        n_checks++;
        if ({load_h, data_h} !== {1'b0, 16'hDEED}) begin
            n_fail++; $display("FAIL basic_hold: got %b %h expected 0 deed", load_h, data_h);
        end
        drive(1, 0, 0, 0, 8'h00);
        n_checks++;
        if ({load_h, addr_h, data_h} !== {1'b1, 16'h0001, 16'h0007}) begin
            n_fail++; $display("FAIL basic_w1: got %b %h %h expected 1 0001 0007", load_h, addr_h, data_h);
        end
    endtask

    task automatic test_frame_start;
        drive(1, 0, 0, 1, 8'hAA);
        drive(1, 1, 0, 0, 8'h00);
        drive(1, 0, 0, 1, 8'h12);
        drive(1, 0, 0, 1, 8'h34);
        n_checks++;
        if (load_h !== 1'b0) begin
            n_fail++; $display("FAIL fs_no_aa_word: got load %b expected 0", load_h);
        end
        drive(1, 0, 0, 0, 8'h00);
        n_checks++;
        if ({load_h, addr_h, data_h, data_l} !== {1'b1, 16'h0000, 16'h1234, 16'h3412}) begin
            n_fail++; $display("FAIL fs_word0: got %b %h %h %h expected 1 0000 1234 3412", load_h, addr_h, data_h, data_l);
        end
        drive(1, 0, 0, 1, 8'hAA);
        drive(1, 1, 0, 1, 8'h55);
        drive(1, 0, 0, 1, 8'h66);
        drive(1, 0, 0, 0, 8'h00);
        n_checks++;
        if ({load_h, addr_h, data_h} !== {1'b1, 16'h0000, 16'h5566}) begin
            n_fail++; $display("FAIL fs_same_cycle: got %b %h %h expected 1 0000 5566", load_h, addr_h, data_h);
        end
    endtask

    task automatic test_pending_load;
        drive(1, 1, 0, 1, 8'h11);
        drive(1, 0, 0, 1, 8'h22);
        drive(1, 1, 0, 0, 8'h00);
        n_checks++;
        if ({load_h, addr_h, data_h} !== {1'b1, 16'h0000, 16'h1122}) begin
            n_fail++; $display("FAIL pending_load: got %b %h %h expected 1 0000 1122", load_h, addr_h, data_h);
        end
        drive(1, 0, 0, 1, 8'h33);
        drive(1, 0, 0, 1, 8'h44);
        drive(1, 0, 0, 0, 8'h00);
        n_checks++;
        if ({load_h, addr_h, data_h} !== {1'b1, 16'h0000, 16'h3344}) begin
            n_fail++; $display("FAIL pending_restart: got %b %h %h expected 1 0000 3344", load_h, addr_h, data_h);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] b [0:9];
        logic [15:0] ea;
        for (int i = 0; i < 10; i++) b[i] = 8'(i * 17 + 1);
        for (int i = 0; i <= 10; i++) begin
            drive(1, i == 0, 0, i < 10, i < 10 ? b[i] : 8'h00);
            n_checks++;
            if (i >= 2 && i % 2 == 0) begin
                ea = 16'((i / 2 - 1) % W);
                if ({load_h, addr_h, data_h, done_h} !== {1'b1, ea, b[i-2], b[i-1], ea == 16'(W - 1)}) begin
                    n_fail++; $display("FAIL wrap_%0d: got %b %h %h %b expected 1 %h %h%h %b", i, load_h, addr_h, data_h, done_h, ea, b[i-2], b[i-1], ea == 16'(W - 1));
                end
            end else if ({load_h, done_h} !== 2'b00) begin
                n_fail++; $display("FAIL wrap_idle_%0d: got load %b done %b expected 0 0", i, load_h, done_h);
            end
        end
    endtask

    task automatic test_reset_abort;
        drive(1, 0, 0, 1, 8'h99);
        drive(0, 0, 0, 0, 8'h00);
        drive(1, 0, 0, 1, 8'hAB);
        drive(1, 0, 0, 1, 8'hCD);
        drive(1, 0, 0, 0, 8'h00);
        n_checks++;
        if ({load_h, addr_h, data_h} !== {1'b1, 16'h0000, 16'hABCD}) begin
            n_fail++; $display("FAIL reset_abort: got %b %h %h expected 1 0000 abcd", load_h, addr_h, data_h);
        end
    endtask

`ifdef FB_LOADER_CLEAR_EN
    task automatic test_clear;
        drive(1, 0, 0, 1, 8'h77);
        drive(1, 1, 1, 0, 8'h00);
        drive(1, 1, 1, 1, 8'hEE);
        n_checks++;
        if ({ready_h, load_h} !== 2'b00) begin
            n_fail++; $display("FAIL clear_enter: got rdy %b load %b expected 0 0", ready_h, load_h);
        end
        for (int k = 0; k < W; k++) begin
            drive(1, 1, 1, 1, 8'hEE);
            n_checks++;
            if ({ready_h, load_h, addr_h, data_h, done_h} !== {2'b01, 16'(k), 16'h0000, k == W - 1}) begin
                n_fail++; $display("FAIL clear_w%0d: got rdy %b ld %b a %h d %h dn %b expected 0 1 %h 0000 %b", k, ready_h, load_h, addr_h, data_h, done_h, 16'(k), k == W - 1);
            end
        end
        drive(1, 0, 0, 1, 8'h01);
        n_checks++;
        if ({ready_h, load_h} !== 2'b10) begin
            n_fail++; $display("FAIL clear_exit: got rdy %b load %b expected 1 0", ready_h, load_h);
        end
        drive(1, 0, 0, 1, 8'h02);
        drive(1, 0, 0, 0, 8'h00);
        n_checks++;
        if ({load_h, addr_h, data_h} !== {1'b1, 16'h0000, 16'h0102}) begin
            n_fail++; $display("FAIL clear_after: got %b %h %h expected 1 0000 0102", load_h, addr_h, data_h);
        end
    endtask

    task automatic test_reset_in_clear;
        drive(1, 0, 1, 0, 8'h00);
        drive(1, 0, 0, 0, 8'h00);
        drive(1, 0, 0, 0, 8'h00);
        drive(1, 0, 0, 0, 8'h00);
        drive(0, 0, 0, 0, 8'h00);
        n_checks++;
        if ({ready_h, load_h, addr_h} !== {2'b01, 16'h0002}) begin
            n_fail++; $display("FAIL rc_before: got rdy %b ld %b a %h expected 0 1 0002", ready_h, load_h, addr_h);
        end
        drive(1, 0, 0, 0, 8'h00);
        n_checks++;
        if ({ready_h, load_h, done_h, addr_h, data_h} !== {3'b100, 32'd0}) begin
            n_fail++; $display("FAIL rc_after: got rdy %b ld %b dn %b a %h d %h expected 1 0 0 0000 0000", ready_h, load_h, done_h, addr_h, data_h);
        end
        drive(1, 0, 0, 0, 8'h00);
        n_checks++;
        if (load_h !== 1'b0) begin
            n_fail++; $display("FAIL rc_no_resume: got load %b expected 0", load_h);
        end
    endtask
`endif

    task automatic test_random;
        for (int i = 0; i < 500; i++)
            drive($urandom_range(99) != 0, $urandom_range(19) == 0, $urandom_range(59) == 0,
                  $urandom_range(3) != 0, 8'($urandom));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_start();
        test_pending_load();
        test_wrap();
        test_reset_abort();
`ifdef FB_LOADER_CLEAR_EN
        test_clear();
        test_reset_in_clear();
`endif
        test_random();
        drive(1, 0, 0, 0, 8'h00);
        drive(1, 0, 0, 0, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fb_loader.md
FB_LOADER -- requirements
Module: fb_loader

Interface
REQ-001 SHALL have parameter WORDS_PER_FRAME, default 24000, meaning number of 16-bit frame-buffer words per frame (800x480 monochrome, 16 pixels/word).
REQ-002 SHALL have parameter HIGH_FIRST, default 1, meaning first byte of a pair goes to write_data[15:8] when 1, to [7:0] when 0.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset_n, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port byte_in, input, 8, pixel byte (8 pixels).
REQ-006 SHALL have port byte_valid, input, 1, byte_in valid.
REQ-007 SHALL have port byte_ready, output, 1, loader can accept a byte.
REQ-008 SHALL have port frame_start, input, 1, restart frame at word 0.
REQ-009 SHALL have port clear_req, input, 1, request whole-frame zero fill (present only with FB_LOADER_CLEAR_EN).
REQ-010 SHALL have port write_address, output, 16, frame-buffer word address.
REQ-011 SHALL have port write_data, output, 16, frame-buffer word data.
REQ-012 SHALL have port load, output, 1, frame-buffer write strobe, one cycle per word.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse on last word of a frame.

Function
REQ-014 A byte SHALL be accepted in a cycle where byte_valid and byte_ready are both 1 at the rising clk edge.
REQ-015 States SHALL be ACCEPT_HI, ACCEPT_LO and CLEAR; ACCEPT_HI -> ACCEPT_LO on acceptance, ACCEPT_LO -> ACCEPT_HI on acceptance.
REQ-016 byte_ready SHALL be 1 in ACCEPT_HI/ACCEPT_LO and 0 in CLEAR and in any cycle with reset_n low.
REQ-017 On acceptance in ACCEPT_LO, the next cycle SHALL present load=1, write_address=word pointer, write_data=packed pair per HIGH_FIRST; latency exactly 1 cycle.
REQ-018 load SHALL be 1 for exactly one cycle per packed word; write_address/write_data SHALL hold their last values while load=0.
REQ-019 Word pointer SHALL increment after each write and wrap from WORDS_PER_FRAME-1 to 0; frame_done SHALL be 1 in the same cycle as the load of address WORDS_PER_FRAME-1.
REQ-020 frame_start SHALL set the pointer to 0 and discard any held first byte; state returns to ACCEPT_HI.
REQ-021 frame_start and acceptance in the same cycle: frame_start applies first, and the accepted byte SHALL become the first byte of word 0.
REQ-022 frame_start arriving in the cycle after a completing byte SHALL NOT suppress that word's pending load; only subsequent words restart at 0.
REQ-023 frame_start and clear_req SHALL be ignored while in CLEAR.

Reset
REQ-024 While reset_n is low at a rising clk edge: state=ACCEPT_HI, pointer=0, held byte=0, write_address=0, write_data=0, load=0, frame_done=0.
REQ-025 reset_n low during CLEAR or with a half-packed word SHALL abort it; no further load until new bytes are accepted.

Configuration
REQ-026 With FB_LOADER_CLEAR_EN defined: clear_req=1 in ACCEPT_HI/ACCEPT_LO SHALL enter CLEAR, discard any held byte, and issue load=1 with write_data=0 on consecutive cycles for addresses 0..WORDS_PER_FRAME-1, frame_done on the last, then return to ACCEPT_HI with pointer 0.
REQ-027 clear_req and frame_start in the same cycle SHALL resolve to clear.
REQ-028 Without FB_LOADER_CLEAR_EN: the clear_req port and CLEAR state SHALL not exist, and byte_ready SHALL equal reset_n.

Verification
REQ-029 Bytes 0xDE,0xED then 0x00,0x07 (HIGH_FIRST=1) -> load at addr 0 data 0xDEED, then addr 1 data 0x0007, each 1 cycle after second byte.
REQ-030 WORDS_PER_FRAME=4, 10 bytes -> addresses 0,1,2,3,0; frame_done exactly with address 3.
REQ-031 Byte 0xAA, frame_start, bytes 0x12,0x34 -> single load addr 0 data 0x1234; 0xAA never written.
REQ-032 HIGH_FIRST=0, bytes 0x12,0x34 -> data 0x3412.
REQ-033 FB_LOADER_CLEAR_EN, WORDS_PER_FRAME=4, clear_req -> 4 consecutive loads data 0 addr 0..3, byte_ready 0 throughout, frame_done at addr 3.
REQ-034 reset_n low for 1 cycle during CLEAR at addr 2 -> load 0 next cycle, all outputs at reset values, byte_ready 1 after release.
